shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 24 ++
 rtl/shift_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer.
//   - Shift register control codes driven on sr_ctrl.
//   - FSM state encoding used by shift_seq_ctrl.
package shift_seq_pkg;

    // Control codes understood by the external shift register.
    localparam logic [1:0] SR_HOLD = 2'd0;  // keep q
    localparam logic [1:0] SR_SHR  = 2'd1;  // right shift, data[N-1] enters the MSB
    localparam logic [1:0] SR_SHL  = 2'd2;  // left shift, data[N-1] enters the LSB
    localparam logic [1:0] SR_LOAD = 2'd3;  // parallel load of data

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_SHIFT = 2'd1,
        RX_SHIFT = 2'd2,
        RX_DONE  = 2'd3
    } state_t;

    // Shift direction for a given bit order: MSB-first uses left shifts.
    function automatic logic [1:0] shift_code(input logic msb_first);
        return msb_first ? SR_SHL : SR_SHR;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer that drives one external N-bit shift register so it behaves as
// either a handshaked serializer (TX) or deserializer (RX).
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   mode, dir          0/1 = TX/RX and LSB-first/MSB-first, sampled in IDLE
//   shift_en           TX bit-rate strobe
//   tx_data/valid/ready  word-level producer handshake
//   ser_out, ser_out_valid  serial TX bit and its consume strobe
//   ser_in, ser_in_valid    serial RX bit and its valid strobe
//   rx_data/valid/ready  word-level consumer handshake
//   rx_overrun         one-cycle pulse when an RX bit had to be dropped
//   busy               controller is not idle
//   sr_ctrl, sr_data   control and data to the shift register
//   sr_q               shift register contents
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int N = 8,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
    input  logic         dir,
    input  logic         shift_en,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         ser_out,
    output logic         ser_out_valid,
    input  logic         ser_in,
    input  logic         ser_in_valid,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         rx_overrun,
    output logic         busy,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_data,
    input  logic [N-1:0] sr_q
);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          dir_reg, dir_next;
    logic          overrun_reg, overrun_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dir_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dir_next      = dir_reg;
        overrun_next  = 1'b0;
        sr_ctrl       = SR_HOLD;
        sr_data       = '0;
        tx_ready      = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = '0;

        unique case (state_reg)
            IDLE: begin
                tx_ready = !mode;
                if (!mode && tx_valid) begin
                    sr_ctrl    = SR_LOAD;
                    sr_data    = tx_data;
                    dir_next   = dir;
                    cnt_next   = '0;
                    state_next = TX_SHIFT;
                end else if (mode && ser_in_valid) begin
                    // The first bit is shifted in on the exit cycle itself,
                    // using the incoming dir since the latched one is not
                    // updated until the clock edge.
                    sr_ctrl          = shift_code(dir);
                    sr_data[N-1]     = ser_in;
                    dir_next         = dir;
                    cnt_next         = CW'(1);
                    state_next       = RX_SHIFT;
                end
            end

            TX_SHIFT: begin
                ser_out       = dir_reg ? sr_q[N-1] : sr_q[0];
                ser_out_valid = shift_en;
                if (shift_en) begin
                    // Zero fill: sr_data stays at its default of 0.
                    sr_ctrl = shift_code(dir_reg);
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            RX_SHIFT: begin
                if (ser_in_valid) begin
                    sr_ctrl      = shift_code(dir_reg);
                    sr_data[N-1] = ser_in;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = RX_DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            RX_DONE: begin
                // Register is held, so rx_data is stable until accepted.
                rx_valid     = 1'b1;
                rx_data      = sr_q;
                overrun_next = ser_in_valid;
                if (rx_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign rx_overrun = overrun_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural model of the
// external shift register.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode, dir, shift_en;
    logic [N-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic         ser_out, ser_out_valid;
    logic         ser_in, ser_in_valid;
    logic [N-1:0] rx_data;
    logic         rx_valid, rx_ready, rx_overrun, busy;
    logic [1:0]   sr_ctrl;
    logic [N-1:0] sr_data;
    logic [N-1:0] sr_q;

    int checks = 0;
    int fails  = 0;

    bit           sb_bits[$];
    logic [N-1:0] sb_words[$];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .dir(dir), .shift_en(shift_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_out(ser_out), .ser_out_valid(ser_out_valid),
        .ser_in(ser_in), .ser_in_valid(ser_in_valid),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .busy(busy),
        .sr_ctrl(sr_ctrl), .sr_data(sr_data), .sr_q(sr_q)
    );

    // External shift register; its active-high reset is the inverted reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            case (sr_ctrl)
                SR_SHR:  sr_q <= {sr_data[N-1], sr_q[N-1:1]};
                SR_SHL:  sr_q <= {sr_q[N-2:0], sr_data[N-1]};
                SR_LOAD: sr_q <= sr_data;
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One TX word; exp_stream bit i is the i-th serial bit out.
    task automatic run_tx(input bit d, input logic [N-1:0] word,
                          input logic [N-1:0] exp_stream, input int pace, input bit toggle);
        int k;
        int pulses;
        bit e;
        @(negedge clk);
        mode = 1'b0; dir = d; tx_data = word; tx_valid = 1'b1; shift_en = 1'b0;
        #1;
        check("tx_ready_idle", 32'(tx_ready), 32'd1);
        check("load_ctrl", 32'(sr_ctrl), 32'(SR_LOAD));
        check("load_data", 32'(sr_data), 32'(word));
        for (int i = 0; i < N; i++) sb_bits.push_back(exp_stream[i]);
        pulses = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = ~word;
            e = ((k % pace) == pace - 1);
            shift_en = e;
            if (toggle) begin
                mode = ~mode;
                dir  = ~dir;
            end
            #1;
            if (!busy) break;
            check("sov_eq_en", 32'(ser_out_valid), 32'(e));
            if (ser_out_valid) begin
                pulses++;
                if (sb_bits.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL tx_extra_bit: got ser_out_valid with no bit expected at %0t", $time);
                end else begin
                    check("ser_out", 32'(ser_out), 32'(sb_bits.pop_front()));
                end
            end
        end
        check("tx_done_bound", 32'(k < 200), 32'd1);
        check("tx_pulses", 32'(pulses), 32'(N));
        check("tx_sb_empty", 32'(sb_bits.size()), 32'd0);
        if (pace == 1) check("tx_latency", 32'(k), 32'(N));
        // Back in IDLE: a mode set during the word only takes effect now.
        @(negedge clk);
        shift_en = 1'b0;
        mode     = toggle;
        tx_valid = 1'b1;
        #1;
        check("idle_tx_ready", 32'(tx_ready), 32'(!toggle));
        if (toggle) check("mode1_ignores_tx", 32'(sr_ctrl), 32'(SR_HOLD));
        @(negedge clk);
        tx_valid = 1'b0;
        mode     = 1'b0;
        dir      = d;
        if (!toggle) begin
            // The idle-check cycle loaded a word; drain it silently.
            shift_en = 1'b1;
            repeat (N) @(negedge clk);
            shift_en = 1'b0;
            #1;
            check("tx_drain_idle", 32'(busy), 32'd0);
        end
        $display("tx word %h dir %0d pace %0d toggle %0d pulses %0d", word, d, pace, toggle, pulses);
    endtask

    // One RX word; stream bit i is the i-th serial bit in.
    task automatic run_rx(input bit d, input logic [N-1:0] stream,
                          input logic [N-1:0] exp_word, input int gap, input bit ovr);
        sb_words.push_back(exp_word);
        for (int i = 0; i < N; i++) begin
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    ser_in_valid = 1'b0; shift_en = 1'b1;
                    #1;
                    check("rx_gap_hold", 32'(sr_ctrl), 32'(SR_HOLD));
                end
            end
            @(negedge clk);
            mode = 1'b1; dir = d; ser_in = stream[i]; ser_in_valid = 1'b1; shift_en = 1'b0;
            #1;
            check("rx_shift_ctrl", 32'(sr_ctrl), 32'(d ? SR_SHL : SR_SHR));
            check("rx_shift_bit", 32'(sr_data[N-1]), 32'(stream[i]));
            check("rx_not_valid", 32'(rx_valid), 32'd0);
        end
        @(negedge clk);
        ser_in_valid = 1'b0; rx_ready = 1'b0; mode = 1'b0; dir = ~d;
        #1;
        check("rx_valid", 32'(rx_valid), 32'd1);
        if (sb_words.size() != 0) check("rx_data", 32'(rx_data), 32'(sb_words.pop_front()));
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            #1;
            check("rx_hold_valid", 32'(rx_valid), 32'd1);
            check("rx_hold_data", 32'(rx_data), 32'(exp_word));
        end
        if (ovr) begin
            @(negedge clk);
            ser_in_valid = 1'b1; ser_in = ~stream[0];
            #1;
            check("ovr_hold_ctrl", 32'(sr_ctrl), 32'(SR_HOLD));
            check("ovr_not_yet", 32'(rx_overrun), 32'd0);
            @(negedge clk);
            ser_in_valid = 1'b0;
            #1;
            check("ovr_pulse", 32'(rx_overrun), 32'd1);
            check("ovr_data", 32'(rx_data), 32'(exp_word));
            check("ovr_busy", 32'(busy), 32'd1);
            @(negedge clk);
            #1;
            check("ovr_single", 32'(rx_overrun), 32'd0);
        end
        @(negedge clk);
        rx_ready = 1'b1;
        #1;
        check("rx_accept_valid", 32'(rx_valid), 32'd1);
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        check("rx_idle_busy", 32'(busy), 32'd0);
        check("rx_idle_valid", 32'(rx_valid), 32'd0);
        $display("rx word %h dir %0d gap %0d overrun %0d", exp_word, d, gap, ovr);
    endtask

    typedef struct {
        bit           mode;
        bit           dir;
        logic [N-1:0] din;    // TX word or RX serial stream (bit i = i-th bit)
        int           pace;   // TX strobe period or RX gap length
        bit           flag;   // TX: toggle mode/dir mid-word; RX: inject overrun
        logic [N-1:0] exp;    // TX serial stream or RX word
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'hA5, 1, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 8'hC3, 3, 1'b0, 8'hC3};
        vecs[2] = '{1'b0, 1'b1, 8'h2D, 2, 1'b1, 8'hB4};
        vecs[3] = '{1'b1, 1'b0, 8'h0B, 2, 1'b1, 8'h0B};
        vecs[4] = '{1'b1, 1'b1, 8'h39, 1, 1'b0, 8'h9C};

        reset_n = 1'b0; mode = 1'b0; dir = 1'b0; shift_en = 1'b0;
        tx_data = '0; tx_valid = 1'b0; ser_in = 1'b0; ser_in_valid = 1'b0; rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_sov", 32'(ser_out_valid), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_sr_ctrl", 32'(sr_ctrl), 32'(SR_HOLD));
        check("rst_sr_data", 32'(sr_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].mode) run_rx(vecs[v].dir, vecs[v].din, vecs[v].exp, vecs[v].pace, vecs[v].flag);
            else              run_tx(vecs[v].dir, vecs[v].din, vecs[v].exp, vecs[v].pace, vecs[v].flag);
        end

        // Reset in the middle of a TX word after three bits.
        sb_bits.delete();
        @(negedge clk);
        mode = 1'b0; dir = 1'b0; tx_data = 8'hFF; tx_valid = 1'b1; shift_en = 1'b0;
        for (int i = 0; i < N; i++) sb_bits.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_valid = 1'b0; shift_en = 1'b1;
            #1;
            check("mid_sov", 32'(ser_out_valid), 32'd1);
            if (sb_bits.size() != 0) check("mid_ser_out", 32'(ser_out), 32'(sb_bits.pop_front()));
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sr_ctrl", 32'(sr_ctrl), 32'(SR_HOLD));
        check("abort_sov", 32'(ser_out_valid), 32'd0);
        check("abort_sr_q", 32'(sr_q), 32'd0);
        @(negedge clk);
        #1;
        check("abort_sov2", 32'(ser_out_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; shift_en = 1'b0;
        sb_bits.delete();
        $display("tx word ff aborted by reset after 3 bits");
        run_tx(1'b0, 8'h01, 8'h01, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
